gpio_test_monitor: RTL and testbench

//  Parametrised on-chip test-completion monitor. Watches NCH GPIO words driven by the SoC

---
 rtl/gpio_mon_pkg.sv | 17 +
 rtl/gpio_mon_filter.sv | 47 ++++
 rtl/gpio_test_monitor.sv | 210 +++++++++++++++++++++
 tb/tb_gpio_test_monitor.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_mon_pkg.sv
// gpio_mon_pkg: shared types for the GPIO test-completion monitor.
// Imported by gpio_mon_filter and gpio_test_monitor.
package gpio_mon_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      PASS,
      FAIL,
      TOUT
   } mon_state_e;

   // Channel index width wide enough for the largest (8-channel) build
   localparam int NCH_MAX = 8;
   localparam int CH_W    = $clog2(NCH_MAX) + 1;

endpackage

// File: rtl/gpio_mon_filter.sv
// gpio_mon_filter: per-channel debounce; a value is accepted after
// STABLE_CYC equal registered samples, with a one-cycle change pulse.
module gpio_mon_filter
   import gpio_mon_pkg::*;
#(
   parameter int W          = 32,
   parameter int STABLE_CYC = 4
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [W-1:0] i_raw,
   output logic [W-1:0] o_filt,
   output logic         o_changed
);

   localparam int SC_W = $clog2(STABLE_CYC + 1);
   localparam logic [SC_W-1:0] SC_MAX = SC_W'(STABLE_CYC);

   logic [W-1:0]    r_samp;
   logic [W-1:0]    r_filt;
   logic [SC_W-1:0] r_cnt;
   logic            r_chg;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_samp <= '0;
         r_filt <= '0;
         r_cnt  <= '0;
         r_chg  <= 1'b0;
      end else begin
         r_samp <= i_raw;
         if (i_raw != r_samp)
            r_cnt <= SC_W'(1);
         else if (r_cnt != SC_MAX)
            r_cnt <= r_cnt + SC_W'(1);
         r_chg <= 1'b0;
         if (r_cnt == SC_MAX && r_samp != r_filt) begin
            r_filt <= r_samp;
            r_chg  <= 1'b1;
         end
      end
   end

   assign o_filt    = r_filt;
   assign o_changed = r_chg;

endmodule

// File: rtl/gpio_test_monitor.sv
// gpio_test_monitor: debounced PASS/FAIL/TIMEOUT verdict from GPIO words.
// Optional change-log FIFO enabled by defining GPIO_MON_LOG_EN.
module gpio_test_monitor
   import gpio_mon_pkg::*;
#(
   parameter int          NCH         = 2,
   parameter int          W           = 32,
   parameter logic [31:0] PASS_CODE   = 32'h600D_600D,
   parameter logic [31:0] FAIL_CODE   = 32'hBAD0_BAD0,
   parameter int          STABLE_CYC  = 4,
   parameter int          TIMEOUT_CYC = 100000,
   parameter int          CNT_W       = 32,
   parameter int          LOG_DEPTH   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [NCH*W-1:0]       gpio_i,
   output logic [NCH-1:0]         changed,
   output logic                   done,
   output logic                   pass,
   output logic                   fail,
   output logic                   timeout,
   output logic [$clog2(NCH):0]   fail_ch,
   output logic [CNT_W-1:0]       cycles,
   input  logic                   log_pop,
   output logic                   log_valid,
   output logic [$clog2(NCH):0]   log_ch,
   output logic [W-1:0]           log_data,
   output logic [CNT_W-1:0]       log_time,
   output logic                   log_ovf
);

   localparam int CW = $clog2(NCH) + 1;
   localparam logic [W-1:0] P_CODE = W'(PASS_CODE);
   localparam logic [W-1:0] F_CODE = W'(FAIL_CODE);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [W-1:0]    w_filt [NCH];
   logic [NCH-1:0]  w_chg;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      gpio_mon_filter #(
         .W          (W),
         .STABLE_CYC (STABLE_CYC)
      ) u_filt (
         .i_clk     (clk),
         .i_rst_n   (rst),
         .i_raw     (gpio_i[c*W +: W]),
         .o_filt    (w_filt[c]),
         .o_changed (w_chg[c])
      );
   end

   assign changed = w_chg;

   logic            w_any_fail;
   logic            w_all_pass;
   logic [CH_W-1:0] w_fail_idx;

   // Descending scan leaves the lowest failing index
   always_comb begin
      w_any_fail = 1'b0;
      w_all_pass = 1'b1;
      w_fail_idx = '0;
      for (int c = NCH - 1; c >= 0; c--) begin
         if (w_filt[c] == F_CODE) begin
            w_any_fail = 1'b1;
            w_fail_idx = CH_W'(c);
         end
         if (w_filt[c] != P_CODE)
            w_all_pass = 1'b0;
      end
   end

   mon_state_e       r_state;
   mon_state_e       w_next;
   logic [CNT_W-1:0] r_cycles;
   logic [CW-1:0]    r_fail_ch;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (!en) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE: w_next = RUN;
            RUN: begin
               if (w_any_fail)
                  w_next = FAIL;
               else if (w_all_pass)
                  w_next = PASS;
               else if (r_cycles == TO_LAST)
                  w_next = TOUT;
            end
            default: w_next = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cycles  <= '0;
         r_fail_ch <= '0;
      end else if (!en) begin
         r_cycles  <= '0;
         r_fail_ch <= '0;
      end else if (r_state == RUN) begin
         if (r_cycles != '1)
            r_cycles <= r_cycles + CNT_W'(1);
         if (w_next == FAIL)
            r_fail_ch <= CW'(w_fail_idx);
      end
   end

   assign pass    = (r_state == PASS);
   assign fail    = (r_state == FAIL);
   assign timeout = (r_state == TOUT);
   assign done    = pass | fail | timeout;
   assign fail_ch = r_fail_ch;
   assign cycles  = r_cycles;

`ifdef GPIO_MON_LOG_EN
   localparam int AW = $clog2(LOG_DEPTH);

   typedef struct packed {
      logic [CW-1:0]    ch;
      logic [W-1:0]     data;
      logic [CNT_W-1:0] tm;
   } log_ent_t;

   log_ent_t     r_mem [LOG_DEPTH];
   logic [AW:0]  r_wp;
   logic [AW:0]  r_rp;
   logic         r_ovf;
   log_ent_t     w_ent;
   log_ent_t     w_head;
   logic         w_req;
   logic         w_multi;
   logic         w_empty;
   logic         w_full;
   logic         w_pop;
   logic         w_push;

   always_comb begin
      w_ent    = '0;
      w_ent.tm = r_cycles;
      for (int c = NCH - 1; c >= 0; c--) begin
         if (w_chg[c]) begin
            w_ent.ch   = CW'(c);
            w_ent.data = w_filt[c];
         end
      end
      w_req   = (|w_chg) && (r_state != IDLE);
      w_multi = w_req && ((w_chg & (w_chg - NCH'(1))) != '0);
   end

   assign w_empty = (r_wp == r_rp);
   assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                    (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign w_pop   = log_pop && !w_empty;
   // A pop frees the slot this push needs
   assign w_push  = w_req && (!w_full || w_pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_ovf <= 1'b0;
      end else if (!en) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_push)
            r_wp <= r_wp + (AW+1)'(1);
         if (w_pop)
            r_rp <= r_rp + (AW+1)'(1);
         if ((w_req && !w_push) || w_multi)
            r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (en && w_push)
         r_mem[r_wp[AW-1:0]] <= w_ent;
   end

   assign w_head    = r_mem[r_rp[AW-1:0]];
   assign log_valid = !w_empty;
   assign log_ch    = w_head.ch;
   assign log_data  = w_head.data;
   assign log_time  = w_head.tm;
   assign log_ovf   = r_ovf;
`else
   logic w_unused_pop;
   assign w_unused_pop = log_pop;
   assign log_valid    = 1'b0;
   assign log_ch       = '0;
   assign log_data     = '0;
   assign log_time     = '0;
   assign log_ovf      = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_test_monitor.sv
// tb_gpio_test_monitor: directed and randomized stimulus checked
// against a behavioural model of the monitor.
module tb_gpio_test_monitor;

   localparam int NCH   = 2;
   localparam int W     = 32;
   localparam int SC    = 4;
   localparam int TO    = 300;
   localparam int CNT_W = 32;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(NCH) + 1;
   localparam logic [W-1:0] PC = 32'h600D_600D;
   localparam logic [W-1:0] FC = 32'hBAD0_BAD0;
   localparam longint CMAX = (longint'(1) << CNT_W) - 1;

   logic               clk = 1'b0;
   logic               rst;
   logic               en;
   logic               log_pop;
   logic [NCH*W-1:0]   gpio_i;
   logic [NCH-1:0]     changed;
   logic               done;
   logic               pass;
   logic               fail;
   logic               timeout;
   logic [CW-1:0]      fail_ch;
   logic [CNT_W-1:0]   cycles;
   logic               log_valid;
   logic [CW-1:0]      log_ch;
   logic [W-1:0]       log_data;
   logic [CNT_W-1:0]   log_time;
   logic               log_ovf;

   gpio_test_monitor #(
      .NCH         (NCH),
      .W           (W),
      .PASS_CODE   (32'h600D_600D),
      .FAIL_CODE   (32'hBAD0_BAD0),
      .STABLE_CYC  (SC),
      .TIMEOUT_CYC (TO),
      .CNT_W       (CNT_W),
      .LOG_DEPTH   (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .gpio_i    (gpio_i),
      .changed   (changed),
      .done      (done),
      .pass      (pass),
      .fail      (fail),
      .timeout   (timeout),
      .fail_ch   (fail_ch),
      .cycles    (cycles),
      .log_pop   (log_pop),
      .log_valid (log_valid),
      .log_ch    (log_ch),
      .log_data  (log_data),
      .log_time  (log_time),
      .log_ovf   (log_ovf)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int pop_pct = 0;

   task automatic chk(input string tag,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h @%0t",
                  tag, act, exp, $time);
      end
   endtask

   // Behavioural model
   typedef struct {
      int           ch;
      logic [W-1:0] d;
      longint       t;
   } ent_t;

   logic [W-1:0] m_win  [NCH][SC];
   logic [W-1:0] m_filt [NCH];
   bit [NCH-1:0] m_chg;
   int           m_n;
   bit           m_run, m_pass, m_fail, m_tout;
   longint       m_cyc;
   int           m_fch;
   ent_t         m_q [$];
   bit           m_ovf;

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_filt[c] = '0;
         for (int k = 0; k < SC; k++) m_win[c][k] = '0;
      end
      m_chg = '0;
      m_n = 0;
      m_run = 0; m_pass = 0; m_fail = 0; m_tout = 0;
      m_cyc = 0;
      m_fch = 0;
      m_q.delete();
      m_ovf = 0;
   endtask

   task automatic model_step();
      logic [W-1:0] of [NCH];
      bit [NCH-1:0] oc;
      bit           idle_o, st, ap, dp, can;
      longint       oy;
      int           lf, first, nset;
      ent_t         e;
      of = m_filt;
      oc = m_chg;
      oy = m_cyc;
      idle_o = !(m_run | m_pass | m_fail | m_tout);
      // Filter: accept a value seen on the last SC samples
      for (int c = 0; c < NCH; c++) begin
         st = (m_n >= SC);
         for (int k = 1; k < SC; k++)
            if (m_win[c][k] != m_win[c][0]) st = 0;
         m_chg[c] = st && (m_win[c][0] != m_filt[c]);
         if (m_chg[c]) m_filt[c] = m_win[c][0];
         for (int k = SC - 1; k > 0; k--)
            m_win[c][k] = m_win[c][k-1];
         m_win[c][0] = gpio_i[c*W +: W];
      end
      m_n++;
      // Verdict
      if (!en) begin
         m_run = 0; m_pass = 0; m_fail = 0; m_tout = 0;
         m_cyc = 0;
         m_fch = 0;
      end else if (idle_o) begin
         m_run = 1;
      end else if (m_run) begin
         lf = -1;
         ap = 1;
         for (int c = 0; c < NCH; c++) begin
            if (of[c] == FC && lf < 0) lf = c;
            if (of[c] != PC) ap = 0;
         end
         if (lf >= 0) begin
            m_run = 0; m_fail = 1; m_fch = lf;
         end else if (ap) begin
            m_run = 0; m_pass = 1;
         end else if (oy == TO - 1) begin
            m_run = 0; m_tout = 1;
         end
         if (m_cyc < CMAX) m_cyc++;
      end
      // Change log
      if (!en) begin
         m_q.delete();
         m_ovf = 0;
      end else begin
         dp = log_pop && (m_q.size() > 0);
         can = (m_q.size() < DEPTH) || dp;
         first = -1;
         nset = 0;
         for (int c = 0; c < NCH; c++)
            if (oc[c]) begin
               nset++;
               if (first < 0) first = c;
            end
         if (dp) void'(m_q.pop_front());
         if (!idle_o && nset > 0) begin
            if (nset > 1) m_ovf = 1;
            if (can) begin
               e.ch = first;
               e.d  = of[first];
               e.t  = oy;
               m_q.push_back(e);
            end else begin
               m_ovf = 1;
            end
         end
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else      model_step();
   end

   task automatic check_all();
      chk("changed", 64'(changed), 64'(m_chg));
      chk("done", 64'(done), 64'(m_pass | m_fail | m_tout));
      chk("pass", 64'(pass), 64'(m_pass));
      chk("fail", 64'(fail), 64'(m_fail));
      chk("timeout", 64'(timeout), 64'(m_tout));
      chk("fail_ch", 64'(fail_ch), 64'(m_fch));
      chk("cycles", 64'(cycles), 64'(m_cyc));
`ifdef GPIO_MON_LOG_EN
      chk("log_valid", 64'(log_valid), 64'(m_q.size() > 0));
      chk("log_ovf", 64'(log_ovf), 64'(m_ovf));
      if (m_q.size() > 0) begin
         chk("log_ch", 64'(log_ch), 64'(m_q[0].ch));
         chk("log_data", 64'(log_data), 64'(m_q[0].d));
         chk("log_time", 64'(log_time), 64'(m_q[0].t));
      end
`else
      chk("log_valid", 64'(log_valid), 64'd0);
      chk("log_ovf", 64'(log_ovf), 64'd0);
      chk("log_ch", 64'(log_ch), 64'd0);
      chk("log_data", 64'(log_data), 64'd0);
      chk("log_time", 64'(log_time), 64'd0);
`endif
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(negedge clk);
         check_all();
         log_pop = ($urandom_range(0, 99) < pop_pct);
      end
   endtask

   task automatic set_ch(input int c, input logic [W-1:0] v);
      gpio_i[c*W +: W] = v;
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return PC;
         2:       return FC;
         default: return W'($urandom());
      endcase
   endfunction

   initial begin
      model_reset();
      rst = 1'b0;
      en = 1'b0;
      log_pop = 1'b0;
      gpio_i = '0;
      @(negedge clk);
      check_all();
      chk("rst_done", 64'(done), 64'd0);
      rst = 1'b1;

      // Idle run, no codes
      en = 1'b1;
      run(201);
      chk("cyc200", 64'(cycles), 64'd200);
      chk("no_verdict", 64'(done), 64'd0);

      // Pass: ch0 then ch1 ten cycles later
      en = 1'b0;
      run(2);
      en = 1'b1;
      run(3);
      set_ch(0, PC);
      run(10);
      set_ch(1, PC);
      run(SC + 1);
      chk("pass_early", 64'(pass), 64'd0);
      run(1);
      chk("pass_at", 64'(pass), 64'd1);
      chk("pass_done", 64'(done), 64'd1);

      // Glitch shorter than the filter, then a real fail on ch1
      en = 1'b0;
      gpio_i = '0;
      run(SC + 3);
      en = 1'b1;
      run(2);
      set_ch(1, FC);
      run(SC - 1);
      set_ch(1, '0);
      run(10);
      chk("glitch", 64'(fail), 64'd0);
      set_ch(1, FC);
      run(SC + 2);
      chk("fail1", 64'(fail), 64'd1);
      chk("fail_ch1", 64'(fail_ch), 64'd1);

      // Both channels fail together: lowest index wins
      en = 1'b0;
      gpio_i = '0;
      run(SC + 3);
      en = 1'b1;
      set_ch(1, PC);
      run(SC + 3);
      set_ch(0, FC);
      set_ch(1, FC);
      run(SC + 2);
      chk("fail_both", 64'(fail), 64'd1);
      chk("fail_ch0", 64'(fail_ch), 64'd0);

      // Timeout and clear
      en = 1'b0;
      set_ch(0, 32'h1234_5678);
      set_ch(1, 32'h0BAD_F00D);
      run(SC + 3);
      en = 1'b1;
      run(TO + 5);
      chk("tout", 64'(timeout), 64'd1);
      chk("tout_cyc", 64'(cycles), 64'(TO));
      en = 1'b0;
      run(1);
      chk("tout_clr", 64'(timeout), 64'd0);
      chk("cyc_clr", 64'(cycles), 64'd0);

      // Nine distinct changes on ch0 without popping
      en = 1'b1;
      run(2);
      for (int i = 0; i < 9; i++) begin
         set_ch(0, 32'h0000_1000 + 32'(i));
         run(SC + 2);
      end
`ifdef GPIO_MON_LOG_EN
      chk("log_ovf9", 64'(log_ovf), 64'd1);
`endif
      pop_pct = 50;
      run(20);

      // Randomized episodes
      for (int ep = 0; ep < 80; ep++) begin
         if ($urandom_range(0, 9) == 0) en = ~en;
         if ($urandom_range(0, 19) == 0) begin
            #2 rst = 1'b0;
            #1 check_all();
            chk("arst_done", 64'(done), 64'd0);
            @(negedge clk);
            check_all();
            rst = 1'b1;
         end
         pop_pct = $urandom_range(0, 70);
         for (int c = 0; c < NCH; c++)
            if ($urandom_range(0, 2) != 0) set_ch(c, pick());
         run($urandom_range(1, SC + 4));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
